// File: rtl/namuru_pkg.sv
// namuru_pkg
//   Shared constants for the Namuru correlator status block: bit positions
//   of the status word and default counter widths. Also used by the
//   register map and the bus decoder.
package namuru_pkg;

    localparam int unsigned STATUS_ACCUM_BIT = 0;
    localparam int unsigned STATUS_TIC_BIT   = 1;
    localparam int unsigned STATUS_OVR_BIT   = 2;
    localparam int unsigned STATUS_WIDTH     = 3;

    localparam int unsigned OVR_WIDTH_DEF    = 8;
    localparam int unsigned EPOCH_WIDTH_DEF  = 32;

endpackage

// File: rtl/namuru_sticky_flag.sv
// namuru_sticky_flag
//   Single sticky flag: set by a one-cycle strobe, held until cleared.
//   A set and a clear in the same cycle leave the flag set, so no event
//   can be lost to a coincident clear.
// Ports:
//   clk  - system clock
//   rstn - synchronous reset, active-high
//   set  - set strobe
//   clr  - clear strobe
//   q    - flag state
module namuru_sticky_flag (
    input  logic clk,
    input  logic rstn,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rstn)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (clr)
            q <= 1'b0;
    end

endmodule

// File: rtl/namuru_status_ctrl.sv
// namuru_status_ctrl
//   Status and interrupt controller behind the time base. Converts the
//   accum/tic strobes into sticky CPU-readable flags, drives the level
//   accumulator interrupt, counts TIC epochs and counts accumulation
//   interrupts that were not serviced before the next one (overruns).
// Ports:
//   clk           - system clock
//   rstn          - synchronous reset, active-high
//   tic_enable    - one-cycle TIC strobe
//   accum_enable  - one-cycle accumulation strobe
//   int_enable    - accumulator interrupt mask (1 = enabled)
//   status_read   - CPU reads status this cycle (clears accum/tic flags)
//   overrun_clear - clears overrun flag and counter
//   status        - {overrun_flag, tic_flag, accum_flag}
//   accum_int     - level interrupt to CPU
//   overrun_count - saturating count of missed accumulation interrupts
//   tic_epoch     - wrapping count of TICs since reset
module namuru_status_ctrl
    import namuru_pkg::*;
#(
    parameter int unsigned OVR_WIDTH   = OVR_WIDTH_DEF,
    parameter int unsigned EPOCH_WIDTH = EPOCH_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    tic_enable,
    input  logic                    accum_enable,
    input  logic                    int_enable,
    input  logic                    status_read,
    input  logic                    overrun_clear,
    output logic [STATUS_WIDTH-1:0] status,
    output logic                    accum_int,
    output logic [OVR_WIDTH-1:0]    overrun_count,
    output logic [EPOCH_WIDTH-1:0]  tic_epoch
);

    logic accum_flag;
    logic tic_flag;
    logic overrun_flag;
    logic overrun_evt;

    // A read in the same cycle consumes the pending interrupt, so a new
    // accum strobe then is not a miss.
    always_comb begin
        overrun_evt = accum_enable & accum_flag & ~status_read;
    end

    namuru_sticky_flag u_accum_flag (
        .clk  (clk),
        .rstn (rstn),
        .set  (accum_enable),
        .clr  (status_read),
        .q    (accum_flag)
    );

    namuru_sticky_flag u_tic_flag (
        .clk  (clk),
        .rstn (rstn),
        .set  (tic_enable),
        .clr  (status_read),
        .q    (tic_flag)
    );

    namuru_sticky_flag u_overrun_flag (
        .clk  (clk),
        .rstn (rstn),
        .set  (overrun_evt),
        .clr  (overrun_clear),
        .q    (overrun_flag)
    );

    always_ff @(posedge clk) begin
        if (rstn)
            overrun_count <= '0;
        else if (overrun_clear)
            overrun_count <= overrun_evt ? OVR_WIDTH'(1) : '0;
        else if (overrun_evt && (overrun_count != '1))
            overrun_count <= overrun_count + OVR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rstn)
            tic_epoch <= '0;
        else if (tic_enable)
            tic_epoch <= tic_epoch + EPOCH_WIDTH'(1);
    end

    always_comb begin
        status                   = '0;
        status[STATUS_ACCUM_BIT] = accum_flag;
        status[STATUS_TIC_BIT]   = tic_flag;
        status[STATUS_OVR_BIT]   = overrun_flag;
    end

    // Mask only gates the output; the flag itself is never affected.
    always_comb begin
        accum_int = accum_flag & int_enable;
    end

endmodule

// File: doc/namuru_status_ctrl.md
# namuru_status_ctrl

Status and interrupt controller for the Namuru GPS correlator, sitting directly downstream of the time base. It turns the single-cycle `accum_enable` and `tic_enable` strobes into sticky, CPU-readable status flags and a level accumulator interrupt. It also counts TIC epochs and detects accumulation interrupts that the CPU did not service before the next one arrived (overruns). The host bus interface drives the read/clear strobes; the status word and counters go to the register read mux.

## Interface
Parameters:
- `OVR_WIDTH`, 8: width of the saturating overrun counter.
- `EPOCH_WIDTH`, 32: width of the wrapping TIC epoch counter.

Ports:
- `clk`  in  1  system clock, same domain as the time base.
- `rstn`  in  1  reset; synchronous, active-high (asserted = 1, sampled on rising `clk`).
- `tic_enable`  in  1  one-cycle TIC strobe from the time base.
- `accum_enable`  in  1  one-cycle accumulation-interrupt strobe from the time base.
- `int_enable`  in  1  interrupt mask from the control register; 1 = accumulator interrupt enabled.
- `status_read`  in  1  one-cycle strobe; CPU is reading the status word this cycle.
- `overrun_clear`  in  1  one-cycle strobe; clears the overrun flag and counter.
- `status`  out  3  {overrun_flag, tic_flag, accum_flag}, bits [2:0].
- `accum_int`  out  1  level interrupt to the CPU.
- `overrun_count`  out  OVR_WIDTH  number of missed accumulation interrupts, saturating.
- `tic_epoch`  out  EPOCH_WIDTH  number of TICs since reset, wrapping.

## Operation
- `accum_flag`:
  - Set on the `clk` edge that samples `accum_enable`=1.
  - Cleared on the edge that samples `status_read`=1.
  - Set wins over clear in the same cycle.
- `tic_flag`: same set/clear rules, driven by `tic_enable`.
- Overrun event: `accum_enable`=1 while `accum_flag`=1 and `status_read`=0.
  - A read in the same cycle means the previous interrupt was consumed, so no overrun is counted.
- `overrun_flag`:
  - Set on an overrun event.
  - Cleared only by `overrun_clear`; `status_read` has no effect on it.
  - Set wins over clear in the same cycle.
- `overrun_count`:
  - Increments by 1 per overrun event and saturates at 2^OVR_WIDTH-1.
  - On `overrun_clear`: loads 0, or loads 1 if an overrun event occurs in the same cycle.
- `tic_epoch`: increments by 1 per `tic_enable`; wraps from all-ones to 0.
- `accum_int` = `accum_flag` AND `int_enable`. This is combinational from registers only, with no input-to-output path apart from `int_enable`.
- Masking with `int_enable` never clears or blocks `accum_flag`. Re-enabling with the flag still set asserts `accum_int` immediately.
- `status` is a direct view of the flag registers.
  - The bus samples it in the same cycle as `status_read`, i.e. the value before the clear.
- Reset values: all flags 0, `overrun_count` 0, `tic_epoch` 0, `accum_int` 0.
- Reset has priority over every strobe in the same cycle.

## Timing
- Strobe to flag: one-cycle latency. A strobe sampled at edge N makes the flag visible after edge N.
- `accum_int` rises in the cycle after `accum_enable`.
  - It falls in the cycle after `status_read`, unless the set-wins rule keeps `accum_flag` at 1.
- `tic_epoch` and `overrun_count` update at the same edge as the corresponding flag.
- Back-to-back strobes on consecutive cycles are legal. Every strobe is counted; no pulse is lost.
- Reset asserted mid-operation: all state reaches its reset value at the next edge.
  - A strobe present during reset is discarded.
  - The first strobe counted is the one sampled in the first cycle with `rstn`=0.

## Structure
- `namuru_pkg`:
  - `STATUS_ACCUM_BIT`=0, `STATUS_TIC_BIT`=1, `STATUS_OVR_BIT`=2.
  - Default widths `OVR_WIDTH_DEF`=8, `EPOCH_WIDTH_DEF`=32.
  - Shared with the register map and the bus decoder.
- Sub-module `namuru_sticky_flag`:
  - Ports: `clk`, `rstn`, `set`, `clr`, `q`.
  - Synchronous reset; set-over-clear priority.
  - Instantiated three times.
- Counters are inline in the top module.

## Test plan
- Reset, then `accum_enable` pulse at cycle 10 → `status`=3'b001 from cycle 11; with `int_enable`=1, `accum_int`=1 from cycle 11. `status_read` at cycle 15 → `status`=0 and `accum_int`=0 from cycle 16.
- `accum_enable` and `status_read` in the same cycle with the flag already set → flag stays 1, `overrun_count` stays 0.
- Three `accum_enable` pulses with no read → `overrun_count`=2, `status[2]`=1. `overrun_clear` together with a 4th pulse → count=1, `status[2]`=1.
- With OVR_WIDTH=2, drive 6 unserviced pulses → count saturates at 3.
- Load `tic_epoch` to 32'hFFFFFFFE via 2^32-2 TICs (force in sim), then 3 `tic_enable` → 32'hFFFFFFFF, 0, 1. `tic_flag` set; `status_read` clears it.
- `int_enable`=0 during `accum_enable` → `accum_int`=0 while `accum_flag`=1. Raising `int_enable` → `accum_int`=1 the same cycle. `rstn` pulse mid-sequence zeroes all outputs at the next edge.
